uart_encoder: RTL and testbench
===============================

Name: uart_encoder

Overview:
Serial UART transmitter: the counterpart of uart_decoder. It accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each byte as an asynchronous frame: start bit, LSB-first data, optional parity, then stop bit(s). In the simulation top it drives uart0_srx_pad_i, giving the SoC's UART receiver a stimulus source. The RTL is synthesizable, so the same block can also serve as a transmit engine in hardware.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period; legal range 2..65535.
FIFO_DEPTH, 16, byte entries in the input FIFO; must be a power of two, 2..256.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  FIFO can accept a byte (equals not-full)
uart_tx  out  1  serial line, idle high
busy  out  1  a frame is in progress or the FIFO is not empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release by the clock domain):
  - FIFO empty, state IDLE, baud counter 0.
  - uart_tx=1, busy=0, fifo_level=0, tx_ready=1.
- Handshake:
  - A byte is accepted on a rising edge with tx_valid && tx_ready.
  - tx_ready is a registered not-full flag.
  - tx_valid while full is ignored; there is no overflow error and the byte is not stored.
- FIFO:
  - Read and write in the same cycle are both performed; level is unchanged.
  - Level wraps never; pointers wrap modulo FIFO_DEPTH.
  - When full, a simultaneous pop and push: the push is accepted only if tx_ready was 1 in that cycle, so it is not accepted at the full level.
- State machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into shift register sh[7:0], load the baud counter with CLKS_PER_BIT-1, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: uart_tx=sh[0]; sh shifts right once per bit. Bit index 0..7; after index 7 go to PARITY if PARITY!=0, else STOP.
  - PARITY: uart_tx = ^byte for even parity, ~^byte for odd parity. Lasts one bit period.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with zero idle gap; otherwise go to IDLE.
- Timing:
  - Baud counter counts down; a bit ends when the counter is 0, then it reloads with CLKS_PER_BIT-1.
  - Latency: a byte accepted at edge N into an empty FIFO in IDLE is popped at edge N+1. uart_tx falls at edge N+2.
  - Frame length: (1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
  - uart_tx is driven from a flop, so it is glitch-free.
- busy = (state!=IDLE) || (fifo_level!=0); registered.
- Reset mid-frame: the line returns to 1 immediately and the FIFO contents are discarded.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, 3-bit);
  - PARITY_NONE/ODD/EVEN constants;
  - the CLKS_PER_BIT counter width function.
- uart_decoder and the bench also use uart_pkg.
- Natural sub-module: uart_tx_fifo, a synchronous FIFO parameterised by width and depth, providing push, pop, full, empty and level.
- The serialiser FSM stays in uart_encoder.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0: push 0xA5 after reset -> uart_tx falls 2 cycles later. Line is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 cycles. busy drops to 0 one cycle after the stop bit ends.
2. Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> three frames of 40 cycles each with no idle cycles between them. fifo_level sequence is 1, 1, 2, then 1, then 0.
3. FIFO_DEPTH=4: hold tx_valid for 8 cycles with data 0x10..0x17 -> tx_ready deasserts when full. Exactly the bytes accepted under handshake are transmitted, in order, and none is duplicated.
4. PARITY=2 with 0x07 -> parity bit 1. PARITY=1 with 0x07 -> parity bit 0. STOP_BITS=2 -> stop high for 8 cycles at CLKS_PER_BIT=4.
5. Assert rst_n low halfway through the data bits of 0x3C with 2 bytes queued -> uart_tx=1 and fifo_level=0 asynchronously. After release, no frame is emitted.
6. Loopback: uart_tx drives uart_decoder with matched period, 256 random bytes -> the decoded stream equals the pushed stream.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, parity modes and baud counter sizing.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Width of a down-counter that must hold CLKS_PER_BIT-1.
   function automatic int cnt_width(input int clks_per_bit);
      return (clks_per_bit < 3) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full flag; pushes while full and pops while empty are dropped.
module uart_tx_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, do_push, do_pop;

   always_comb begin
      do_push = push_i && !full_q;
      do_pop  = pop_i && (level_q != '0);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
      end
   end

   // Storage is not reset: reset only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign full_o  = full_q;
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

endmodule

// File: rtl/uart_encoder.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser with a registered line.
module uart_encoder
   import uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = 868,
   parameter  int FIFO_DEPTH   = 16,
   parameter  int PARITY       = PARITY_NONE,
   parameter  int STOP_BITS    = 1,
   localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic          uart_tx,
   output logic          busy,
   output logic [LW-1:0] fifo_level
);

   localparam int            CW        = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);
   localparam logic          ODD       = (PARITY == PARITY_ODD);

   uart_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    sh_q, fifo_rdata;
   logic          stop_q, par_q, tx_q, busy_q;
   logic          fifo_full, fifo_empty, pop;

   uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (tx_valid),
      .wdata_i (tx_data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Popping at the last stop cycle chains frames with no idle gap.
   assign pop = !fifo_empty &&
                ((state_q == ST_IDLE) ||
                 (state_q == ST_STOP && cnt_q == '0 && stop_q == STOP_LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_q != ST_IDLE) || (fifo_level != '0);
         case (state_q)
            ST_START:  tx_q <= 1'b0;
            ST_DATA:   tx_q <= sh_q[0];
            ST_PARITY: tx_q <= par_q ^ ODD;
            default:   tx_q <= 1'b1;
         endcase
         if (pop) begin
            sh_q    <= fifo_rdata;
            par_q   <= ^fifo_rdata;
            cnt_q   <= BIT_LAST;
            state_q <= ST_START;
         end else if (state_q != ST_IDLE) begin
            if (cnt_q != '0) begin
               cnt_q <= cnt_q - CW'(1);
            end else begin
               cnt_q <= BIT_LAST;
               case (state_q)
                  ST_START: begin
                     state_q <= ST_DATA;
                     idx_q   <= '0;
                  end
                  ST_DATA: begin
                     sh_q  <= sh_q >> 1;
                     idx_q <= idx_q + 3'd1;
                     if (idx_q == 3'd7) begin
                        state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
                        stop_q  <= 1'b0;
                     end
                  end
                  ST_PARITY: begin
                     state_q <= ST_STOP;
                     stop_q  <= 1'b0;
                  end
                  ST_STOP: begin
                     if (stop_q == STOP_LAST) state_q <= ST_IDLE;
                     else                     stop_q  <= 1'b1;
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign tx_ready = !fifo_full;
   assign uart_tx  = tx_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_encoder.sv
// Four encoder configurations share one stimulus stream; each is compared every cycle against a
// frame-level model, plus directed literal checks and a loopback receiver on the plain 8N1 instance.
module tb_uart_encoder;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [7:0] tx_data  = '0;
   logic       tx_valid = 1'b0;
   logic [3:0] txl_all, bsy_all;
   logic [9:0] pat      = 10'b1101001010;
   logic [7:0] sentq[$];
   logic       rx_en    = 1'b0;
   int         rx_cnt   = 0;
   int         n_chk    = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // cfg0: 8N1 depth16, cfg1: 8N1 depth4, cfg2: even parity 2 stop, cfg3: odd parity 1 stop
   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int DEP = (g == 1) ? 4 : 16;
      localparam int PAR = (g == 2) ? PARITY_EVEN : (g == 3) ? PARITY_ODD : PARITY_NONE;
      localparam int STP = (g == 2) ? 2 : 1;
      localparam int NB  = 1 + 8 + ((PAR != PARITY_NONE) ? 1 : 0) + STP;
      localparam int LW  = $clog2(DEP) + 1;

      logic          rdy, txl, bsy;
      logic [LW-1:0] lvl;
      logic [7:0]    fq[$];
      logic          lq[$];
      logic          active = 1'b0;

      uart_encoder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .PARITY(PAR), .STOP_BITS(STP)) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .tx_data    (tx_data),
         .tx_valid   (tx_valid),
         .tx_ready   (rdy),
         .uart_tx    (txl),
         .busy       (bsy),
         .fifo_level (lvl)
      );

      assign txl_all[g] = txl;
      assign bsy_all[g] = bsy;

      always @(posedge clk or negedge rst_n) begin
         logic       acc, exp_line, exp_busy, fbit;
         logic [7:0] b;
         if (!rst_n) begin
            fq.delete();
            lq.delete();
            active = 1'b0;
            #1;
            chk($sformatf("cfg%0d reset line", g), 32'(txl), 1);
            chk($sformatf("cfg%0d reset level", g), 32'(lvl), 0);
            chk($sformatf("cfg%0d reset ready", g), 32'(rdy), 1);
            chk($sformatf("cfg%0d reset busy", g), 32'(bsy), 0);
         end else begin
            acc      = tx_valid && (fq.size() < DEP);
            exp_busy = active || (fq.size() != 0);
            exp_line = (lq.size() != 0) ? lq.pop_front() : 1'b1;
            if (lq.size() == 0 && fq.size() != 0) begin
               b = fq.pop_front();
               for (int j = 0; j < NB; j++) begin
                  if (j == 0)      fbit = 1'b0;
                  else if (j <= 8) fbit = b[j-1];
                  else if (j == 9 && PAR != PARITY_NONE)
                     fbit = (PAR == PARITY_EVEN) ? ^b : ~^b;
                  else             fbit = 1'b1;
                  repeat (CPB) lq.push_back(fbit);
               end
            end
            if (acc) fq.push_back(tx_data);
            active = (lq.size() != 0);
            #1;
            chk($sformatf("cfg%0d line", g), 32'(txl), 32'(exp_line));
            chk($sformatf("cfg%0d level", g), 32'(lvl), fq.size());
            chk($sformatf("cfg%0d ready", g), 32'(rdy), 32'(fq.size() < DEP));
            chk($sformatf("cfg%0d busy", g), 32'(bsy), 32'(exp_busy));
         end
      end
   end

   task automatic wait_idle();
      int k;
      tick();
      for (k = 0; k < 3000; k++) begin
         if (bsy_all == 4'b0000) break;
         tick();
      end
      chk("idle wait within budget", 32'(k < 3000), 1);
   endtask

   // Loopback receiver sampling mid-bit on the 8N1 instance.
   initial begin : rx
      logic [7:0] rb;
      wait (rx_en);
      forever begin
         @(negedge txl_all[0]);
         repeat (2) @(posedge clk);
         #1 chk("rx start bit", 32'(txl_all[0]), 0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rb[i] = txl_all[0];
         end
         repeat (CPB) @(posedge clk);
         #1 chk("rx stop bit", 32'(txl_all[0]), 1);
         chk("rx byte expected", 32'(sentq.size() != 0), 1);
         if (sentq.size() != 0) chk("rx byte", 32'(rb), 32'(sentq.pop_front()));
         rx_cnt++;
      end
   end

   initial begin : main
      int zeros;
      repeat (3) tick();
      chk("reset line literal", 32'(txl_all[0]), 1);
      chk("reset level literal", 32'(cfg[0].lvl), 0);
      rst_n = 1'b1;
      tick();
      tick();

      // 0xA5 framing and latency
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick();
      chk("t1 line idle at N+1", 32'(txl_all[0]), 1);
      for (int j = 0; j < 10; j++)
         for (int r = 0; r < CPB; r++) begin
            tick();
            chk($sformatf("t1 bit%0d", j), 32'(txl_all[0]), 32'(pat[j]));
         end
      chk("t1 busy last stop", 32'(bsy_all[0]), 1);
      tick();
      chk("t1 busy after frame", 32'(bsy_all[0]), 0);

      // back-to-back frames
      wait_idle();
      tx_valid = 1'b1; tx_data = 8'h00;
      tick(); chk("t2 level M", 32'(cfg[0].lvl), 1);
      tx_data = 8'hFF;
      tick(); chk("t2 level M+1", 32'(cfg[0].lvl), 1);
      tx_data = 8'h55;
      tick(); chk("t2 level M+2", 32'(cfg[0].lvl), 2);
      chk("t2 line falls M+2", 32'(txl_all[0]), 0);
      tx_valid = 1'b0;
      repeat (38) tick(); chk("t2 level M+40", 32'(cfg[0].lvl), 2);
      tick(); chk("t2 level M+41", 32'(cfg[0].lvl), 1);
      chk("t2 stop M+41", 32'(txl_all[0]), 1);
      tick(); chk("t2 no gap M+42", 32'(txl_all[0]), 0);
      repeat (38) tick(); chk("t2 level M+80", 32'(cfg[0].lvl), 1);
      tick(); chk("t2 level M+81", 32'(cfg[0].lvl), 0);
      repeat (40) tick(); chk("t2 busy M+121", 32'(bsy_all[0]), 1);
      tick(); chk("t2 busy M+122", 32'(bsy_all[0]), 0);

      // overflow on the depth-4 instance
      wait_idle();
      tx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tx_data = 8'(8'h10 + i);
         tick();
         if (i == 3) chk("t3 ready before full", 32'(cfg[1].rdy), 1);
         if (i == 4) begin
            chk("t3 ready when full", 32'(cfg[1].rdy), 0);
            chk("t3 level full", 32'(cfg[1].lvl), 4);
         end
      end
      tx_valid = 1'b0;
      chk("t3 depth16 level", 32'(cfg[0].lvl), 7);
      repeat (33) tick(); chk("t3 ready K+40", 32'(cfg[1].rdy), 0);
      tick(); chk("t3 ready K+41", 32'(cfg[1].rdy), 1);
      chk("t3 level K+41", 32'(cfg[1].lvl), 3);

      // parity and two stop bits
      wait_idle();
      tx_data = 8'h07; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      for (int t = 1; t <= 50; t++) begin
         tick();
         if (t == 38) begin
            chk("t4 even parity bit", 32'(txl_all[2]), 1);
            chk("t4 odd parity bit", 32'(txl_all[3]), 0);
         end
         if (t == 45) chk("t4 odd busy end", 32'(bsy_all[3]), 1);
         if (t == 46) chk("t4 odd busy drop", 32'(bsy_all[3]), 0);
         if (t == 49) begin
            chk("t4 second stop", 32'(txl_all[2]), 1);
            chk("t4 2stop busy end", 32'(bsy_all[2]), 1);
         end
         if (t == 50) chk("t4 2stop busy drop", 32'(bsy_all[2]), 0);
      end

      // reset mid-frame
      wait_idle();
      tx_valid = 1'b1;
      tx_data = 8'h3C; tick();
      tx_data = 8'h81; tick();
      tx_data = 8'h42; tick();
      tx_valid = 1'b0;
      repeat (29) tick();
      chk("t5 line low before reset", 32'(txl_all[0]), 0);
      chk("t5 level before reset", 32'(cfg[0].lvl), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 async line", 32'(txl_all[0]), 1);
      chk("t5 async level", 32'(cfg[0].lvl), 0);
      chk("t5 async busy", 32'(bsy_all[0]), 0);
      repeat (3) tick();
      #2 rst_n = 1'b1;
      zeros = 0;
      repeat (100) begin
         tick();
         if (txl_all != 4'b1111) zeros++;
      end
      chk("t5 no frame after reset", 32'(zeros), 0);
      chk("t5 level after reset", 32'(cfg[0].lvl), 0);

      // loopback with 256 random bytes
      rx_en = 1'b1;
      for (int bst = 0; bst < 32; bst++) begin
         tx_valid = 1'b1;
         for (int k = 0; k < 8; k++) begin
            tx_data = 8'($urandom);
            sentq.push_back(tx_data);
            tick();
         end
         tx_valid = 1'b0;
         repeat (340) tick();
      end
      wait_idle();
      repeat (10) tick();
      chk("t6 bytes received", 32'(rx_cnt), 256);
      chk("t6 nothing left", 32'(sentq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
